fix_query_sequencer: RTL and testbench
======================================

// Module: fix_query_sequencer
// PURPOSE
//  Sequences one tag lookup over the stored-message datapath: message-location table -> tag CAM -> value RAM.
//  Accepts (message number, tag) requests over a valid/ready handshake and returns the 256-bit value with a hit flag.
//  Owns all read-side strobes of those three resources; only one lookup is in flight at a time.
//  Sits between host/query logic and the parser storage, replacing free-running read control.
// PARAMETERS
//  NUM_MESSAGE  10   message-location table depth; MSG_W = $clog2(NUM_MESSAGE) (localparam)
//  ADDR_WIDTH   5    tag CAM / value RAM index width
//  TAG_WIDTH    32   FIX tag width
//  VALUE_WIDTH  256  value RAM data width
//  SEARCH_TMO   32   max cycles to wait for cam_done_i before aborting
// PORTS
//  clk            in   1            clock, rising edge
//  rst            in   1            asynchronous, active-low reset
//  req_valid_i    in   1            request valid
//  req_ready_o    out  1            request accepted when valid&ready
//  req_msg_i      in   MSG_W        message number to query
//  req_tag_i      in   TAG_WIDTH    tag to find
//  msg_count_i    in   MSG_W+1      number of complete messages currently stored
//  loc_re_o       out  1            location-table read strobe (1 cycle)
//  loc_idx_o      out  MSG_W        location-table read index
//  loc_start_i    in   ADDR_WIDTH   message start index; valid the cycle after loc_re_o
//  loc_end_i      in   ADDR_WIDTH   message end index; valid the cycle after loc_re_o
//  cam_search_o   out  1            CAM search strobe (1 cycle)
//  cam_tag_o      out  TAG_WIDTH    search key; held for the whole search
//  cam_start_o    out  ADDR_WIDTH   search window start; held
//  cam_end_o      out  ADDR_WIDTH   search window end, inclusive; held
//  cam_done_i     in   1            search complete (pulse)
//  cam_match_i    in   1            tag found; qualified by cam_done_i
//  cam_index_i    in   ADDR_WIDTH   matching index; qualified by cam_done_i & cam_match_i
//  val_oe_o       out  1            value RAM read strobe (1 cycle)
//  val_addr_o     out  ADDR_WIDTH   value RAM read address
//  val_data_i     in   VALUE_WIDTH  read data; valid the cycle after val_oe_o
//  resp_valid_o   out  1            response valid; held until resp_ready_i
//  resp_ready_i   in   1            response consumed
//  resp_hit_o     out  1            1 = tag found, value valid
//  resp_err_o     out  1            1 = bad message number or CAM timeout
//  resp_value_o   out  VALUE_WIDTH  value; all-zero when hit = 0
//  busy_o         out  1            1 when state != IDLE
// BEHAVIOUR
//  Reset (rst = 0, async): state IDLE; all outputs 0; timeout counter 0; request/response registers cleared.
//  req_ready_o = (state == IDLE). On accept, latch msg and tag.
//  FSM:
//   IDLE -> LOC_RD on accept
//   LOC_RD: if msg >= msg_count_i, go to RESP with err = 1 and no loc_re_o;
//           else pulse loc_re_o with loc_idx_o = msg, go to LOC_WT
//   LOC_WT: latch loc_start_i / loc_end_i, go to SEARCH
//   SEARCH: pulse cam_search_o on entry; hold key and window; count cycles
//           cam_done_i & match  -> VAL_RD (latch index)
//           cam_done_i & !match -> RESP with hit = 0, err = 0
//           count == SEARCH_TMO-1 without done -> RESP with err = 1
//   VAL_RD: pulse val_oe_o with val_addr_o = index, go to VAL_WT
//   VAL_WT: latch val_data_i, hit = 1, go to RESP
//   RESP: resp_valid_o = 1; on resp_ready_i go to IDLE and clear resp_*
//  Response fields are registered and stable while resp_valid_o is high.
//  Latency, accept to resp_valid_o: 1+1+(search cycles)+2+1. With cam_done_i one cycle after
//  cam_search_o, a hit takes 7 cycles. A bad message number takes 2 cycles.
//  Wrapped window (cam_start_o > cam_end_o) is passed through unchanged; the CAM interprets the wrap.
//  cam_done_i outside SEARCH is ignored. resp_ready_i while resp_valid_o is low is ignored.
//  Async reset mid-lookup aborts immediately; no strobe is asserted in the following cycle.
// STRUCTURE
//  Shared package fix_parser_pkg holds:
//   - typedef enum logic [2:0] {IDLE, LOC_RD, LOC_WT, SEARCH, VAL_RD, VAL_WT, RESP} fqs_state_t
//   - FIX_TAG_W = 32, FIX_VALUE_W = 256
//  No sub-module: one always_ff for FSM and latches, one always_comb for next state and strobes.
// TESTING
//  1. msg_count = 3, req msg 1 / tag 35; loc = (4, 9); CAM done+match idx 6 after 1 cycle;
//     RAM data 'hA5 -> resp hit = 1, value = 'hA5, resp_valid_o 7 cycles after accept; cam window 4..9.
//  2. msg_count = 2, req msg 2 -> no loc_re_o, resp err = 1, hit = 0, value = 0, 2 cycles after accept.
//  3. CAM done with match = 0 -> resp hit = 0, err = 0; val_oe_o never asserted.
//  4. CAM never responds -> resp err = 1 after exactly SEARCH_TMO cycles in SEARCH; later stray cam_done_i ignored.
//  5. resp_ready_i low for 5 cycles -> resp_* stable; req_ready_o low; second request held off until consumed.
//  6. rst low in SEARCH -> all outputs 0 asynchronously; after release, a new request completes normally.

Source files
------------

// File: rtl/fix_parser_pkg.sv
// fix_parser_pkg: shared state encoding and FIX field widths for the stored-message query path
package fix_parser_pkg;
  localparam int FIX_TAG_W = 32;
  localparam int FIX_VALUE_W = 256;
  typedef enum logic [2:0] {IDLE, LOC_RD, LOC_WT, SEARCH, VAL_RD, VAL_WT, RESP} fqs_state_t;
endpackage

// File: rtl/fix_query_sequencer.sv
// fix_query_sequencer: runs one (message, tag) lookup through location table -> tag CAM -> value RAM
//   req_*   : valid/ready request carrying message number and tag
//   msg_count_i : number of complete messages stored (bounds the message number)
//   loc_*   : location-table read strobe/index and returned start/end window
//   cam_*   : CAM search strobe, held key/window, and done/match/index result
//   val_*   : value RAM read strobe/address and returned data
//   resp_*  : registered response (hit, err, value) held until resp_ready_i
//   busy_o  : a lookup is in progress
module fix_query_sequencer
  import fix_parser_pkg::*;
#(
  parameter int NUM_MESSAGE = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH = FIX_TAG_W,
  parameter int VALUE_WIDTH = FIX_VALUE_W,
  parameter int SEARCH_TMO = 32,
  localparam int MSG_W = $clog2(NUM_MESSAGE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [MSG_W-1:0]       req_msg_i,
  input  logic [TAG_WIDTH-1:0]   req_tag_i,
  input  logic [MSG_W:0]         msg_count_i,
  output logic                   loc_re_o,
  output logic [MSG_W-1:0]       loc_idx_o,
  input  logic [ADDR_WIDTH-1:0]  loc_start_i,
  input  logic [ADDR_WIDTH-1:0]  loc_end_i,
  output logic                   cam_search_o,
  output logic [TAG_WIDTH-1:0]   cam_tag_o,
  output logic [ADDR_WIDTH-1:0]  cam_start_o,
  output logic [ADDR_WIDTH-1:0]  cam_end_o,
  input  logic                   cam_done_i,
  input  logic                   cam_match_i,
  input  logic [ADDR_WIDTH-1:0]  cam_index_i,
  output logic                   val_oe_o,
  output logic [ADDR_WIDTH-1:0]  val_addr_o,
  input  logic [VALUE_WIDTH-1:0] val_data_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic                   resp_hit_o,
  output logic                   resp_err_o,
  output logic [VALUE_WIDTH-1:0] resp_value_o,
  output logic                   busy_o
);
  localparam int CW = $clog2(SEARCH_TMO + 1);
  fqs_state_t state, nxt;
  logic [MSG_W-1:0] msg;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CW-1:0] cnt;
  logic bad, tmo, consume;
  assign bad = {1'b0, msg} >= msg_count_i;
  assign tmo = cnt == CW'(SEARCH_TMO - 1);
  assign consume = resp_valid_o && resp_ready_i;
  assign req_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign loc_re_o = state == LOC_RD && !bad;
  assign loc_idx_o = msg;
  // the search strobe fires only on the first SEARCH cycle; key and window stay registered
  assign cam_search_o = state == SEARCH && cnt == '0;
  assign val_oe_o = state == VAL_RD;
  assign val_addr_o = idx;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid_i ? LOC_RD : IDLE;
      LOC_RD:  nxt = bad ? RESP : LOC_WT;
      LOC_WT:  nxt = SEARCH;
      SEARCH:  nxt = cam_done_i ? (cam_match_i ? VAL_RD : RESP) : (tmo ? RESP : SEARCH);
      VAL_RD:  nxt = VAL_WT;
      VAL_WT:  nxt = RESP;
      RESP:    nxt = consume ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  // response fields start cleared, so a miss or error only needs to set what differs from zero;
  // resp_valid_o rises one cycle after entering RESP so the fields are settled before it is seen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      msg <= '0;
      idx <= '0;
      cnt <= '0;
      cam_tag_o <= '0;
      cam_start_o <= '0;
      cam_end_o <= '0;
      resp_valid_o <= 1'b0;
      resp_hit_o <= 1'b0;
      resp_err_o <= 1'b0;
      resp_value_o <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (req_valid_i) begin
          msg <= req_msg_i;
          cam_tag_o <= req_tag_i;
        end
        LOC_RD: if (bad) resp_err_o <= 1'b1;
        LOC_WT: begin
          cam_start_o <= loc_start_i;
          cam_end_o <= loc_end_i;
          cnt <= '0;
        end
        SEARCH: begin
          cnt <= cnt + 1'b1;
          if (cam_done_i && cam_match_i) idx <= cam_index_i;
          if (!cam_done_i && tmo) resp_err_o <= 1'b1;
        end
        VAL_WT: begin
          resp_value_o <= val_data_i;
          resp_hit_o <= 1'b1;
        end
        RESP: begin
          resp_valid_o <= !consume;
          if (consume) begin
            resp_hit_o <= 1'b0;
            resp_err_o <= 1'b0;
            resp_value_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fix_query_sequencer.sv
// tb_fix_query_sequencer: directed scoreboard bench for fix_query_sequencer with location/CAM/RAM models
module tb_fix_query_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [3:0] req_msg_i = '0;
  logic [31:0] req_tag_i = '0;
  logic [4:0] msg_count_i = '0;
  logic loc_re_o;
  logic [3:0] loc_idx_o;
  logic [4:0] loc_start_i = '0;
  logic [4:0] loc_end_i = '0;
  logic cam_search_o;
  logic [31:0] cam_tag_o;
  logic [4:0] cam_start_o;
  logic [4:0] cam_end_o;
  logic cam_done_i = 1'b0;
  logic cam_match_i = 1'b0;
  logic [4:0] cam_index_i = '0;
  logic val_oe_o;
  logic [4:0] val_addr_o;
  logic [255:0] val_data_i = '0;
  logic resp_valid_o;
  logic resp_ready_i = 1'b0;
  logic resp_hit_o;
  logic resp_err_o;
  logic [255:0] resp_value_o;
  logic busy_o;

  fix_query_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_msg_i(req_msg_i), .req_tag_i(req_tag_i),
    .msg_count_i(msg_count_i),
    .loc_re_o(loc_re_o), .loc_idx_o(loc_idx_o), .loc_start_i(loc_start_i), .loc_end_i(loc_end_i),
    .cam_search_o(cam_search_o), .cam_tag_o(cam_tag_o), .cam_start_o(cam_start_o), .cam_end_o(cam_end_o),
    .cam_done_i(cam_done_i), .cam_match_i(cam_match_i), .cam_index_i(cam_index_i),
    .val_oe_o(val_oe_o), .val_addr_o(val_addr_o), .val_data_i(val_data_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_hit_o(resp_hit_o),
    .resp_err_o(resp_err_o), .resp_value_o(resp_value_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hit;
    logic err;
    logic [255:0] value;
    int lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int loc_re_cnt = 0;
  int val_oe_cnt = 0;
  int search_cnt = 0;
  int cam_mode = 0;
  logic cam_pend = 1'b0;
  logic [4:0] cam_idx = '0;
  logic [4:0] obs_start = '0;
  logic [4:0] obs_end = '0;
  logic [31:0] obs_tag = '0;
  logic [4:0] loc_s [10];
  logic [4:0] loc_e [10];
  logic [255:0] val_mem [32];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample strobes after the edge and drive the memory/CAM model responses
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cam_done_i = 1'b0;
    cam_match_i = 1'b0;
    if (cam_pend) begin
      cam_done_i = 1'b1;
      cam_match_i = cam_mode == 0;
      cam_index_i = cam_idx;
      cam_pend = 1'b0;
    end
    if (cam_search_o) begin
      search_cnt++;
      obs_start = cam_start_o;
      obs_end = cam_end_o;
      obs_tag = cam_tag_o;
      if (cam_mode != 2) cam_pend = 1'b1;
    end
    if (loc_re_o) begin
      loc_re_cnt++;
      loc_start_i = loc_s[loc_idx_o];
      loc_end_i = loc_e[loc_idx_o];
    end
    if (val_oe_o) begin
      val_oe_cnt++;
      val_data_i = val_mem[val_addr_o];
    end
  endtask

  task automatic send(input logic [3:0] m, input logic [31:0] t, input logic h, input logic e,
                      input logic [255:0] v, input int l);
    int n = 0;
    while (!req_ready_o && n < 50) begin
      tick();
      n++;
    end
    req_msg_i = m;
    req_tag_i = t;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    acc_cyc = cyc;
    sb.push_back('{h, e, v, l});
  endtask

  task automatic wait_resp();
    exp_t x;
    int n = 0;
    while (!resp_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk("resp_valid_seen", resp_valid_o, 1'b1);
    x = sb.pop_front();
    chk("resp_hit", resp_hit_o, x.hit);
    chk("resp_err", resp_err_o, x.err);
    chk("resp_value", resp_value_o, x.value);
    chk("latency", cyc - acc_cyc, x.lat);
  endtask

  task automatic consume();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("cleared_valid", resp_valid_o, 1'b0);
    chk("cleared_value", resp_value_o, '0);
    chk("cleared_hit_err", {resp_hit_o, resp_err_o}, 2'b00);
    chk("idle_ready", req_ready_o, 1'b1);
  endtask

  initial begin
    int lre, voe, sc;
    logic [255:0] v0;
    for (int i = 0; i < 10; i++) begin
      loc_s[i] = 5'(i);
      loc_e[i] = 5'(i + 2);
    end
    for (int i = 0; i < 32; i++) val_mem[i] = {8'(i), 240'h0, 8'(i + 100)};
    loc_s[1] = 5'd4;
    loc_e[1] = 5'd9;
    val_mem[6] = 256'hA5;
    // reset state
    tick();
    tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", req_ready_o, 1'b1);
    chk("rst_strobes", {loc_re_o, cam_search_o, val_oe_o}, 3'b000);
    chk("rst_resp", {resp_valid_o, resp_hit_o, resp_err_o}, 3'b000);
    chk("rst_cam_key", {cam_tag_o, cam_start_o, cam_end_o}, '0);
    #2 rst = 1'b1;
    // 1: hit through the whole datapath
    msg_count_i = 5'd3;
    cam_mode = 0;
    cam_idx = 5'd6;
    send(4'd1, 32'd35, 1'b1, 1'b0, 256'hA5, 7);
    wait_resp();
    chk("t1_window", {obs_start, obs_end}, {5'd4, 5'd9});
    chk("t1_key", obs_tag, 32'd35);
    consume();
    // 2: message number beyond stored count
    msg_count_i = 5'd2;
    lre = loc_re_cnt;
    send(4'd2, 32'd35, 1'b0, 1'b1, '0, 2);
    wait_resp();
    chk("t2_no_loc_re", loc_re_cnt - lre, 0);
    consume();
    // 3: CAM miss on a wrapped window
    msg_count_i = 5'd3;
    cam_mode = 1;
    loc_s[0] = 5'd28;
    loc_e[0] = 5'd3;
    voe = val_oe_cnt;
    send(4'd0, 32'd44, 1'b0, 1'b0, '0, 5);
    wait_resp();
    chk("t3_wrap_window", {obs_start, obs_end}, {5'd28, 5'd3});
    chk("t3_no_val_oe", val_oe_cnt - voe, 0);
    consume();
    // 4: CAM silent -> timeout, then a stray done in IDLE
    cam_mode = 2;
    send(4'd2, 32'd55, 1'b0, 1'b1, '0, 35);
    wait_resp();
    consume();
    cam_done_i = 1'b1;
    cam_match_i = 1'b1;
    tick();
    chk("t4_stray_busy", busy_o, 1'b0);
    tick();
    chk("t4_stray_resp", {busy_o, resp_valid_o}, 2'b00);
    // 5: held response backpressures a second request
    cam_mode = 0;
    send(4'd1, 32'd35, 1'b1, 1'b0, 256'hA5, 7);
    wait_resp();
    v0 = resp_value_o;
    req_msg_i = 4'd0;
    req_tag_i = 32'd77;
    req_valid_i = 1'b1;
    loc_s[0] = 5'd2;
    loc_e[0] = 5'd12;
    cam_idx = 5'd9;
    sc = search_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", resp_valid_o, 1'b1);
      chk("t5_hold_fields", {resp_hit_o, resp_err_o, resp_value_o}, {2'b10, v0});
      chk("t5_ready_low", req_ready_o, 1'b0);
    end
    chk("t5_no_new_search", search_cnt - sc, 0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("t5_consumed", {resp_valid_o, req_ready_o}, 2'b01);
    tick();
    req_valid_i = 1'b0;
    acc_cyc = cyc;
    sb.push_back('{1'b1, 1'b0, val_mem[9], 7});
    wait_resp();
    chk("t5_second_key", obs_tag, 32'd77);
    consume();
    // 6: asynchronous reset during SEARCH
    cam_mode = 2;
    send(4'd1, 32'd66, 1'b1, 1'b0, 256'hA5, 7);
    tick();
    tick();
    tick();
    chk("t6_in_search", busy_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_busy", {busy_o, resp_valid_o}, 2'b00);
    chk("t6_async_strobes", {loc_re_o, cam_search_o, val_oe_o}, 3'b000);
    chk("t6_async_key", {cam_tag_o, cam_start_o, cam_end_o}, '0);
    sb.delete();
    cam_pend = 1'b0;
    tick();
    chk("t6_no_strobe_after", {loc_re_o, cam_search_o, val_oe_o, busy_o}, 4'b0000);
    #2 rst = 1'b1;
    cam_mode = 0;
    cam_idx = 5'd6;
    send(4'd1, 32'd35, 1'b1, 1'b0, 256'hA5, 7);
    wait_resp();
    consume();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
